// File: rtl/sum_stream.sv
// sum_stream: handshaked WIDTH-bit adder with pairwise and accumulate modes.
// One registered output stage. Overflow wraps or saturates and sets ovf.
//
// Ports:
//   clk       rising-edge clock
//   aresetn   asynchronous active-low reset
//   mode      0 = pairwise, 1 = accumulate (sampled on the first beat of a group)
//   in_valid  / in_ready   input beat handshake (operands a, b)
//   out_valid / out_ready  result handshake (c, ovf)
//   c         result
//   ovf       overflow occurred while forming c
module sum_stream #(
  parameter int WIDTH   = 8,
  parameter int ACC_LEN = 4,
  parameter int SAT     = 0
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  localparam int CW =
    (ACC_LEN > 2) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(ACC_LEN - 1);
  localparam bit CLAMP = (SAT != 0);

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             ovfa_q;
  logic             ovfa_d;

  logic             vld_d;
  logic [WIDTH-1:0] c_d;
  logic             ovf_d;

  logic             fire;
  logic             last;
  logic [WIDTH:0]   s1;
  logic [WIDTH+1:0] s2;
  logic             o1;
  logic             o2;
  logic [WIDTH-1:0] f1;
  logic [WIDTH-1:0] f2;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // Pairwise / first-beat sum and the
  // running-accumulator sum.
  assign s1 = {1'b0, a} + {1'b0, b};
  assign s2 = {2'b00, acc_q}
            + {2'b00, a}
            + {2'b00, b};

  assign o1 = s1[WIDTH];
  assign o2 = |s2[WIDTH+1:WIDTH];

  // A saturated acc sits at all-ones, so any
  // later add also clamps and it stays there.
  assign f1 = (CLAMP && o1) ? '1
            : s1[WIDTH-1:0];
  assign f2 = (CLAMP && o2) ? '1
            : s2[WIDTH-1:0];

  assign last = (cnt_q == LAST);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovfa_d  = ovfa_q;
    vld_d   = out_valid && !out_ready;
    c_d     = c;
    ovf_d   = ovf;
    if (fire) begin
      unique case (1'b1)
        (state_q == IDLE && !mode): begin
          vld_d = 1'b1;
          c_d   = f1;
          ovf_d = o1;
        end
        (state_q == IDLE && mode): begin
          state_d = ACC;
          acc_d   = f1;
          cnt_d   = CW'(1);
          ovfa_d  = o1;
        end
        (state_q == ACC && last): begin
          vld_d   = 1'b1;
          c_d     = f2;
          ovf_d   = ovfa_q | o2;
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovfa_d  = 1'b0;
        end
        default: begin
          acc_d  = f2;
          cnt_d  = cnt_q + 1'b1;
          ovfa_d = ovfa_q | o2;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovfa_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovfa_q  <= ovfa_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      c         <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= vld_d;
      c         <= c_d;
      ovf       <= ovf_d;
    end
  end

endmodule

// File: doc/sum_stream.md
Name: sum_stream

Overview:
- Parametrised, handshaked successor of the registered 8-bit adder.
- Adds two WIDTH-bit operands per accepted beat.
- Two run-time modes:
  - pairwise: one result per beat.
  - accumulate: one result per ACC_LEN beats.
- Overflow is either wrapped or saturated, with an overflow flag.
- Sits between a valid/ready producer and consumer in the datapath, with one registered output stage.

Parameters:
- WIDTH, 8, operand and result width in bits (>=2).
- ACC_LEN, 4, beats summed per result in accumulate mode (>=2).
- SAT, 0, overflow handling: 0 = wrap modulo 2^WIDTH, 1 = clamp to 2^WIDTH-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- aresetn  input  1  asynchronous active-low reset.
- mode  input  1  0 = pairwise, 1 = accumulate; sampled on first beat of a group.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  c/ovf valid.
- out_ready  input  1  consumer accepts result.
- c  output  WIDTH  result.
- ovf  output  1  overflow occurred in the result (wrap or clamp).

Behaviour:
- Reset:
  - Asynchronous on aresetn low: out_valid=0, c=0, ovf=0, acc=0, beat counter=0, state=IDLE.
  - Reset mid-group discards the partial group entirely; no stale output after release.
- Handshake:
  - Beat accepted when in_valid && in_ready.
  - Result consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational; applies to every beat, final or not).
  - out_valid, c and ovf are stable while out_valid=1 and out_ready=0.
  - in_valid not required to stay high; no combinational path from in_valid to out_valid.
- States:
  - IDLE: no group open.
  - ACC: accumulate group open, holds acc, sticky ovf_acc and counter cnt (0..ACC_LEN-1).
- Pairwise (mode=0 sampled in IDLE):
  - Accepted beat computes s = a + b at WIDTH+1 bits; state stays IDLE.
  - Next edge: c = wrap ? s[WIDTH-1:0] : (s[WIDTH] ? all-ones : s[WIDTH-1:0]); ovf = s[WIDTH]; out_valid=1.
  - Latency 1 cycle; throughput 1 beat/cycle under out_ready=1.
- Accumulate (mode=1 sampled in IDLE):
  - First accepted beat: acc = f(a+b), cnt=1, ovf_acc = overflow of that add, go to ACC.
  - Each further beat: t = acc + a + b at WIDTH+2 bits.
    - Overflow when t >= 2^WIDTH.
    - Wrap: acc = t mod 2^WIDTH.
    - Sat: acc = min(t, 2^WIDTH-1); once clamped, acc stays at max for the rest of the group.
    - ovf_acc is sticky (ORed) across the group.
  - On the ACC_LEN-th accepted beat:
    - Next edge: c = final acc, ovf = ovf_acc, out_valid=1.
    - acc, cnt and ovf_acc clear; return to IDLE.
  - No output for intermediate beats.
  - mode is ignored while in ACC; a change takes effect only at the next IDLE beat.
- Simultaneous events:
  - Consume and accept in the same cycle: the output register loads the new result if that beat produces one, else out_valid drops to 0.
  - No bubble under continuous pairwise traffic with out_ready=1.
- Gaps: in_valid=0 cycles inside a group leave acc/cnt unchanged.

Test Plan:
1. WIDTH=8, mode=0, a=3, b=5, out_ready=1 -> one cycle later out_valid=1, c=8, ovf=0.
2. mode=0, a=200, b=100:
   - SAT=0 -> c=44, ovf=1.
   - SAT=1 -> c=255, ovf=1.
3. mode=1, ACC_LEN=4, beats (1,2), (3,4), (5,6), (7,8) -> out_valid stays 0 for the first 3 beats; after the 4th, a single output c=36, ovf=0.
4. Backpressure:
   - Pairwise result c=8 pending with out_ready=0 -> in_ready=0, c stays 8 across 5 cycles, and a presented beat (9,1) is not lost.
   - Raising out_ready -> c=8 consumed, then c=10 next.
5. Reset mid-group: mode=1, 2 beats (10,10), (10,10), then aresetn pulsed low between edges -> out_valid=0 immediately. Beats (1,1)x4 after release -> c=8, ovf=0.
6. Mode change mid-group plus accumulate overflow:
   - mode=1, mode driven to 0 after the first beat, 4 beats of (100,100), SAT=0 -> single output c=32 (800 mod 256), ovf=1.
   - Same with SAT=1 -> c=255, ovf=1.
